multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I datapath. Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, every write enable and the ALU operation. Uses the latched instruction word and the ALU flags (Zero, cout, overflow, sign).
- Stalls on a memory ready handshake. Halts on ECALL/EBREAK or an illegal opcode.

---
 rtl/multicycle_controller.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Purpose : main control FSM of the multicycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Latency : outputs are combinational from state + instr; one state per clock, 3..5+ cycles per instruction.
// Backpr. : FETCH, MEMREAD and MEMWRITE hold until mem_ready=1; HALT holds until reset.
//
// Ports:
//   clk, reset         : clock, synchronous active-low reset (0 = reset)
//   instr              : latched instruction register
//   Zero/cout/overflow/sign : ALU flags, consumed in BRANCH
//   mem_ready          : memory access done this cycle
//   PCWrite/IRWrite/RegWrite/memwrite : write enables (forced 0 while reset=0)
//   AdrSrc/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUControl : datapath selects
//   halted             : sticky, set on entering HALT
//   instret            : retired-instruction counter
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        cout,
    input  logic        overflow,
    input  logic        sign,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        memwrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECR    = 4'd2,
        S_EXECI    = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWB    = 4'd7,
        S_MEMWRITE = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t      r_state;
    state_t      w_next;
    logic        r_halted;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic        w_taken;
    logic        w_retire;
    logic        w_pc_write, w_ir_write, w_reg_write, w_mem_write;
    logic        w_unused;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    assign w_funct7b5 = instr[30];
    assign w_unused   = ^{instr[31], instr[29:15], instr[11:7]};

    // funct7[5] selects SUB only for R-type, but selects SRA for both R and I shifts.
    function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch condition from the SUB flags: signed compare uses sign^overflow,
    // unsigned compare uses carry (cout=1 means no borrow, i.e. A >= B).
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = ~Zero;
            3'b100:  w_taken = sign ^ overflow;
            3'b101:  w_taken = ~(sign ^ overflow);
            3'b110:  w_taken = ~cout;
            3'b111:  w_taken = cout;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= state_t'(RESET_STATE);
            r_halted  <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_retire    = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ResultSrc   = 2'd0;
        ImmSrc      = IMM_I;
        ALUControl  = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'd2;
                w_ir_write = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC <= PC+4 from FETCH's ALUOut while the ALU forms OldPC+imm.
                w_pc_write = 1'b1;
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd1;
                ImmSrc     = (w_opcode == OP_BRANCH) ? IMM_B : IMM_J;
                case (w_opcode)
                    OP_R:      w_next = S_EXECR;
                    OP_I:      w_next = S_EXECI;
                    OP_LOAD:   w_next = S_MEMADR;
                    OP_STORE:  w_next = S_MEMADR;
                    OP_BRANCH: w_next = S_BRANCH;
                    OP_JAL:    w_next = S_JAL;
                    OP_JALR:   w_next = S_JALR;
                    OP_LUI:    w_next = S_LUI;
                    OP_AUIPC:  w_next = S_AUIPC;
                    default:   w_next = S_HALT;
                endcase
            end
            S_EXECR: begin
                ALUSrcA    = 2'd2;
                ALUControl = f_alu_op(w_funct3, w_funct7b5, 1'b1);
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'd2;
                ALUSrcB    = 2'd1;
                ALUControl = f_alu_op(w_funct3, w_funct7b5, 1'b0);
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
                ImmSrc  = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next  = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc   = 2'd1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                ALUSrcA    = 2'd2;
                ALUControl = ALU_SUB;
                ImmSrc     = IMM_B;
                // funct3 010/011 are not branch encodings.
                if (w_funct3[2:1] == 2'b01) begin
                    w_next = S_HALT;
                end else begin
                    w_pc_write = w_taken;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_JAL: begin
                w_pc_write = 1'b1;
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
                w_next  = S_JALRPC;
            end
            S_JALRPC: begin
                // Target bit 0 is passed through unmasked.
                w_pc_write = 1'b1;
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc      = IMM_U;
                ResultSrc   = 2'd2;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                ImmSrc  = IMM_U;
                w_next  = S_ALUWB;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are gated by reset so nothing is written while reset is held.
    assign PCWrite  = w_pc_write  & reset;
    assign IRWrite  = w_ir_write  & reset;
    assign RegWrite = w_reg_write & reset;
    assign memwrite = w_mem_write & reset;
    assign halted   = r_halted;
    assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : scoreboard bench for multicycle_controller; a per-instruction reference model emits the expected control trace.
// Latency : one expected control vector per clock, compared at the falling edge.
// Backpr. : mem_ready wait states are randomised in FETCH, MEMREAD and MEMWRITE.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        Zero, cout, overflow, sign, mem_ready;
    logic        PCWrite, IRWrite, RegWrite, memwrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        halted;
    logic [31:0] instret;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .instr(instr),
        .Zero(Zero), .cout(cout), .overflow(overflow), .sign(sign),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .memwrite(memwrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pcw, irw, rw, mw, adr;
        logic [1:0]  asa, asb, rs;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        hlt;
        logic [31:0] ret;
    } ctrl_t;

    ctrl_t       sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    logic [31:0] m_instret;
    bit          m_halted;

    function automatic ctrl_t mk(input bit pcw, irw, rw, mw, adr,
                                 input logic [1:0] asa, asb, rs,
                                 input logic [2:0] imm, input logic [3:0] alu);
        ctrl_t c;
        c = '0;
        c.pcw = pcw; c.irw = irw; c.rw = rw; c.mw = mw; c.adr = adr;
        c.asa = asa; c.asb = asb; c.rs = rs; c.imm = imm; c.alu = alu;
        return c;
    endfunction

    function automatic string fmt(input ctrl_t c);
        return $sformatf("pcw=%0b irw=%0b rw=%0b mw=%0b adr=%0b asa=%0d asb=%0d rs=%0d imm=%0d alu=%0d hlt=%0b instret=%0d",
                         c.pcw, c.irw, c.rw, c.mw, c.adr, c.asa, c.asb, c.rs, c.imm, c.alu, c.hlt, c.ret);
    endfunction

    // ALU code table indexed by funct3; the alternate encoding (funct7[5]) is the next code up.
    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input bit alt, input bit is_r);
        logic [3:0] base [8];
        logic [3:0] r;
        base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        r = base[f3];
        if (alt && (f3 == 3'd5 || (f3 == 3'd0 && is_r))) r = r + 4'd1;
        return r;
    endfunction

    function automatic bit exp_taken(input logic [2:0] f3, input logic [3:0] fl);
        bit z, c, o, s;
        {z, c, o, s} = fl;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return s != o;
            3'd5: return s == o;
            3'd6: return !c;
            default: return c;
        endcase
    endfunction

    // Drive one clock's worth of inputs and enqueue the control vector expected for that clock.
    task automatic cyc(input bit rst, input bit mr, input logic [31:0] ins,
                       input logic [3:0] fl, input ctrl_t e, input bit retire);
        @(posedge clk);
        #1;
        reset = rst;
        mem_ready = mr;
        instr = ins;
        {Zero, cout, overflow, sign} = fl;
        e.hlt = m_halted;
        e.ret = m_instret;
        sb_q.push_back(e);
        if (retire) m_instret = m_instret + 32'd1;
    endtask

    function automatic logic [3:0] rf();
        return 4'($urandom);
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic reset_cycles();
        m_halted = 1'b0;
        m_instret = 32'd0;
        repeat (2) cyc(1'b0, 1'b1, $urandom, rf(), mk(0,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd0), 1'b0);
    endtask

    task automatic halt_seq(input logic [31:0] ins);
        m_halted = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc((i == 9) ? 1'b0 : 1'b1, rb(), ins, rf(), mk(0,0,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b0);
        reset_cycles();
    endtask

    // fwait/mwait: mem_ready-low cycles before the handshake; fl_br: branch flags (<0 = random).
    task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait, input int fl_br);
        logic [6:0] op;
        logic [2:0] f3;
        bit         alt;
        logic [3:0] fl;
        op  = ins[6:0];
        f3  = ins[14:12];
        alt = ins[30];
        for (int i = 0; i < fwait; i++)
            cyc(1'b1, 1'b0, ins, rf(), mk(0,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd0), 1'b0);
        cyc(1'b1, 1'b1, ins, rf(), mk(0,1,0,0,0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd0), 1'b0);
        cyc(1'b1, rb(), ins, rf(),
            mk(1,0,0,0,0, 2'd1, 2'd1, 2'd0, (op == 7'b1100011) ? 3'd2 : 3'd4, 4'd0), 1'b0);
        case (op)
            7'b0110011, 7'b0010011: begin
                cyc(1'b1, rb(), ins, rf(),
                    mk(0,0,0,0,0, 2'd2, (op == 7'b0110011) ? 2'd0 : 2'd1, 2'd0, 3'd0,
                       exp_alu(f3, alt, op == 7'b0110011)), 1'b0);
                cyc(1'b1, rb(), ins, rf(), mk(0,0,1,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b1);
            end
            7'b0000011: begin
                cyc(1'b1, rb(), ins, rf(), mk(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0), 1'b0);
                for (int i = 0; i < mwait; i++)
                    cyc(1'b1, 1'b0, ins, rf(), mk(0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b0);
                cyc(1'b1, 1'b1, ins, rf(), mk(0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b0);
                cyc(1'b1, rb(), ins, rf(), mk(0,0,1,0,0, 2'd0, 2'd0, 2'd1, 3'd0, 4'd0), 1'b1);
            end
            7'b0100011: begin
                cyc(1'b1, rb(), ins, rf(), mk(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0), 1'b0);
                for (int i = 0; i < mwait; i++)
                    cyc(1'b1, 1'b0, ins, rf(), mk(0,0,0,1,1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b0);
                cyc(1'b1, 1'b1, ins, rf(), mk(0,0,0,1,1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b1);
            end
            7'b1100011: begin
                fl = (fl_br < 0) ? rf() : 4'(fl_br);
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    cyc(1'b1, rb(), ins, fl, mk(0,0,0,0,0, 2'd2, 2'd0, 2'd0, 3'd2, 4'd1), 1'b0);
                    halt_seq(ins);
                end else begin
                    cyc(1'b1, rb(), ins, fl,
                        mk(exp_taken(f3, fl),0,0,0,0, 2'd2, 2'd0, 2'd0, 3'd2, 4'd1), 1'b1);
                end
            end
            7'b1101111, 7'b1100111, 7'b0010111: begin
                if (op == 7'b1100111)
                    cyc(1'b1, rb(), ins, rf(), mk(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0), 1'b0);
                if (op == 7'b0010111)
                    cyc(1'b1, rb(), ins, rf(), mk(0,0,0,0,0, 2'd1, 2'd1, 2'd0, 3'd3, 4'd0), 1'b0);
                else
                    cyc(1'b1, rb(), ins, rf(), mk(1,0,0,0,0, 2'd1, 2'd2, 2'd0, 3'd0, 4'd0), 1'b0);
                cyc(1'b1, rb(), ins, rf(), mk(0,0,1,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0), 1'b1);
            end
            7'b0110111: begin
                cyc(1'b1, rb(), ins, rf(), mk(0,0,1,0,0, 2'd0, 2'd0, 2'd2, 3'd3, 4'd0), 1'b1);
            end
            default: halt_seq(ins);
        endcase
    endtask

    // Monitor: pops one expected vector per clock and compares against the live outputs.
    initial begin : monitor
        ctrl_t exp_v, act_v;
        while (!done) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                act_v = {PCWrite, IRWrite, RegWrite, memwrite, AdrSrc, ALUSrcA, ALUSrcB,
                         ResultSrc, ImmSrc, ALUControl, halted, instret};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL ctrl@%0t: actual {%s} required {%s}", $time, fmt(act_v), fmt(exp_v));
                end
            end
        end
    end

    initial begin : stimulus
        logic [6:0]  ops [10];
        logic [31:0] r;
        logic [6:0]  op;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
        reset = 1'b0; mem_ready = 1'b1; instr = 32'd0;
        {Zero, cout, overflow, sign} = 4'd0;
        reset_cycles();

        run_instr(32'h002081B3, 0, 0, -1);      // add
        run_instr(32'h402081B3, 0, 0, -1);      // sub
        run_instr(32'h00208463, 0, 0, 4'b1000); // beq, Zero=1 -> taken
        run_instr(32'h00208463, 1, 0, 4'b0000); // beq, Zero=0 -> not taken
        run_instr(32'h0020E463, 0, 0, 4'b0000); // bltu, cout=0 -> taken
        run_instr(32'h0040A183, 0, 3, -1);      // lw, 3 wait states
        run_instr(32'h0030A223, 0, 0, -1);      // sw, ready at once
        run_instr(32'h4050D193, 2, 0, -1);      // srai
        run_instr(32'h12345037, 0, 0, -1);      // lui
        run_instr(32'hFFFFFFFF, 0, 0, -1);      // illegal -> halt, then reset

        for (int n = 0; n < 300; n++) begin
            r  = $urandom;
            op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 29) == 0) op = 7'b1110011;
            run_instr({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending, required 0", sb_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
